adder_fu_arbiter: RTL and testbench

Shares one `half_adder` functional unit inside a CGRA tile among `NREQ` requesters (e.g. routing ports feeding the FU). Arbitrates round-robin and latches the winner's operands. It drives the FU's `a`/`b`/`on_off` and waits for `ack`, then returns sum and carry to the winner over a valid/ready response channel. The FU is powered (`on_off=1`) only while an operation is in flight.

---
 rtl/adder_fu_arbiter_pkg.sv | 19 +
 rtl/adder_fu_arbiter_rr_arbiter.sv | 37 +++
 rtl/adder_fu_arbiter.sv | 157 +++++++++++++++
 tb/tb_adder_fu_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_fu_arbiter_pkg.sv
// Shared state type, default parameters and index-width helper
// for the adder FU arbiter and its round-robin sub-block.
package adder_fu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } arb_state_t;

   localparam int DEF_WIDTH   = 16;
   localparam int DEF_NREQ    = 4;
   localparam int DEF_TIMEOUT = 8;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/adder_fu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: search starts one past last_grant.
// Ports: req (NREQ), last_grant (idx) -> gnt (one-hot), gnt_idx, any.
module rr_arbiter
   import adder_fu_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ
) (
   input  logic [NREQ-1:0]         req,
   input  logic [idx_w(NREQ)-1:0]  last_grant,
   output logic [NREQ-1:0]         gnt,
   output logic [idx_w(NREQ)-1:0]  gnt_idx,
   output logic                    any
);

   localparam int IW = idx_w(NREQ);

   logic          found;
   logic [IW-1:0] cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IW'((int'(last_grant) + k) % NREQ);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/adder_fu_arbiter.sv
// Shares one half_adder FU among NREQ requesters: round-robin accept,
// drive FU while in flight, return sum/carry on a valid/ready channel.
// Ports: clk, reset (async high); req_valid/req_ready/req_a/req_b;
// rsp_valid/rsp_ready/rsp_c/rsp_carry/rsp_err; fu_a/fu_b/fu_on_off;
// fu_c/fu_carry_out/fu_ack; busy.
// Optional macro ADDER_FU_ARB_TIMEOUT_EN: abort EXEC after TIMEOUT
// cycles without fu_ack and respond with rsp_err=1, zero result.
module adder_fu_arbiter
   import adder_fu_arb_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NREQ    = DEF_NREQ,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       rsp_valid,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]      rsp_c,
   output logic                  rsp_carry,
   output logic                  rsp_err,
   output logic [WIDTH-1:0]      fu_a,
   output logic [WIDTH-1:0]      fu_b,
   output logic                  fu_on_off,
   input  logic [WIDTH-1:0]      fu_c,
   input  logic                  fu_carry_out,
   input  logic                  fu_ack,
   output logic                  busy
);

   localparam int IW = idx_w(NREQ);

   arb_state_t state, state_d;

   logic [NREQ-1:0]  gnt;
   logic [IW-1:0]    gnt_idx;
   logic [IW-1:0]    g_q;
   logic [IW-1:0]    last_grant;
   logic             any;
   logic             accept;
   logic             done;
   logic             tmo;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] c_q;
   logic             carry_q;
   logic             err_q;

   rr_arbiter #(
      .NREQ(NREQ)
   ) u_rr (
      .req       (req_valid),
      .last_grant(last_grant),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .any       (any)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d   = state;
      accept    = 1'b0;
      done      = 1'b0;
      req_ready = '0;
      rsp_valid = '0;
      fu_on_off = 1'b0;
      unique case (state)
         IDLE: begin
            // gnt only ever selects a valid bit, so any=handshake
            req_ready = gnt;
            if (any) begin
               accept  = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            fu_on_off = 1'b1;
            if (fu_ack || tmo) state_d = RESP;
         end
         RESP: begin
            rsp_valid[g_q] = 1'b1;
            if (rsp_ready[g_q]) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q        <= '0;
         b_q        <= '0;
         g_q        <= '0;
         last_grant <= IW'(NREQ - 1);
         c_q        <= '0;
         carry_q    <= 1'b0;
      end else begin
         if (accept) begin
            a_q        <= req_a[int'(gnt_idx)*WIDTH +: WIDTH];
            b_q        <= req_b[int'(gnt_idx)*WIDTH +: WIDTH];
            g_q        <= gnt_idx;
            last_grant <= gnt_idx;
         end
         if (state == EXEC && fu_ack) begin
            c_q     <= fu_c;
            carry_q <= fu_carry_out;
         end else if (state == EXEC && tmo) begin
            c_q     <= '0;
            carry_q <= 1'b0;
         end
      end
   end

`ifdef ADDER_FU_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)              cnt <= '0;
      else if (accept)        cnt <= '0;
      else if (state == EXEC) cnt <= cnt + CW'(1);
   end

   // ack wins in the final allowed cycle
   assign tmo = !fu_ack && (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                      err_q <= 1'b0;
      else if (state == EXEC && tmo)  err_q <= 1'b1;
      else if (done)                  err_q <= 1'b0;
   end
`else
   logic unused_tmo;
   assign unused_tmo = (TIMEOUT == 0);
   assign tmo        = 1'b0;
   assign err_q      = 1'b0;
`endif

   assign fu_a      = a_q;
   assign fu_b      = b_q;
   assign rsp_c     = c_q;
   assign rsp_carry = carry_q;
   assign rsp_err   = err_q;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_adder_fu_arbiter.sv
// Directed bench for adder_fu_arbiter with a registered-ack FU model
// and a transaction-level scoreboard checked on every falling edge.
module tb_adder_fu_arbiter;

   localparam int W = 16;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a = '0;
   logic [N*W-1:0] req_b = '0;
   logic [N-1:0]   rsp_valid;
   logic [N-1:0]   rsp_ready = '0;
   logic [W-1:0]   rsp_c;
   logic           rsp_carry;
   logic           rsp_err;
   logic [W-1:0]   fu_a;
   logic [W-1:0]   fu_b;
   logic           fu_on_off;
   logic [W-1:0]   fu_c;
   logic           fu_carry_out;
   logic           fu_ack;
   logic           busy;
   logic           fu_stall = 1'b0;

   int nchk = 0;
   int nerr = 0;

   adder_fu_arbiter #(
      .WIDTH(W), .NREQ(N), .TIMEOUT(8)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_c(rsp_c), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
      .fu_a(fu_a), .fu_b(fu_b), .fu_on_off(fu_on_off),
      .fu_c(fu_c), .fu_carry_out(fu_carry_out), .fu_ack(fu_ack),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Ideal half_adder: registered result, ack one cycle after on_off
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         fu_ack       <= 1'b0;
         fu_c         <= '0;
         fu_carry_out <= 1'b0;
      end else begin
         fu_ack <= fu_on_off && !fu_stall;
         {fu_carry_out, fu_c} <= {1'b0, fu_a} + {1'b0, fu_b};
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_rst(string tag);
      chk({tag, "_req_ready"}, req_ready, 0);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_c"}, rsp_c, 0);
      chk({tag, "_rsp_carry"}, rsp_carry, 0);
      chk({tag, "_rsp_err"}, rsp_err, 0);
      chk({tag, "_fu_a"}, fu_a, 0);
      chk({tag, "_fu_b"}, fu_b, 0);
      chk({tag, "_fu_on_off"}, fu_on_off, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   function automatic int rr_pick(logic [N-1:0] v, int last);
      for (int k = 1; k <= N; k++)
         if (v[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   typedef struct {
      int           idx;
      logic [W-1:0] c;
      logic         cy;
      logic         err;
   } exp_t;

   exp_t q[$];
   int   m_last = N - 1;

   // One outstanding transaction at a time; the queue holds what the
   // winner must receive back.
   always @(negedge clk) begin : scoreboard
      int         w;
      logic [W:0] s;
      exp_t       e;
      if (reset) begin
         chk_rst("rst");
         q.delete();
         m_last = N - 1;
      end else begin
         chk("busy", busy, q.size() != 0);
         if (q.size() == 0) begin
            chk("rsp_valid_idle", rsp_valid, 0);
            chk("fu_off_idle", fu_on_off, 0);
            w = rr_pick(req_valid, m_last);
            chk("req_ready", req_ready, (w < 0) ? 0 : (1 << w));
            if (w >= 0) begin
               s = {1'b0, req_a[w*W +: W]} + {1'b0, req_b[w*W +: W]};
               e.idx = w;
               e.c   = s[W-1:0];
               e.cy  = s[W];
               e.err = 1'b0;
`ifdef ADDER_FU_ARB_TIMEOUT_EN
               if (fu_stall) begin
                  e.c   = '0;
                  e.cy  = 1'b0;
                  e.err = 1'b1;
               end
`endif
               q.push_back(e);
               m_last = w;
            end
         end else begin
            chk("req_ready_busy", req_ready, 0);
            if (rsp_valid != 0) begin
               chk("rsp_onehot", rsp_valid, 1 << q[0].idx);
               chk("rsp_c_model", rsp_c, q[0].c);
               chk("rsp_carry_model", rsp_carry, q[0].cy);
               chk("rsp_err_model", rsp_err, q[0].err);
               chk("fu_off_resp", fu_on_off, 0);
               if (rsp_ready[q[0].idx]) void'(q.pop_front());
            end else begin
               chk("fu_on_exec", fu_on_off, 1);
            end
         end
      end
   end

   task automatic set_op(int r, logic [W-1:0] a, logic [W-1:0] b);
      req_a[r*W +: W] = a;
      req_b[r*W +: W] = b;
      req_valid[r]    = 1'b1;
   endtask

   task automatic wait_accept(int r);
      int n = 0;
      @(negedge clk);
      while (!req_ready[r] && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", req_ready[r], 1);
      @(posedge clk);
      #1;
      req_valid[r] = 1'b0;
   endtask

   task automatic wait_rsp(int r, int exp_lat, logic [W-1:0] exp_c,
                           logic exp_cy, logic exp_err, int hold);
      int lat = 1;
      @(negedge clk);
      while (!rsp_valid[r] && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (exp_lat > 0) chk("latency", lat, exp_lat);
      chk("rsp_c", rsp_c, exp_c);
      chk("rsp_carry", rsp_carry, exp_cy);
      chk("rsp_err", rsp_err, exp_err);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         chk("bp_valid", rsp_valid, 1 << r);
         chk("bp_c", rsp_c, exp_c);
         chk("bp_on_off", fu_on_off, 0);
         chk("bp_req_ready", req_ready, 0);
      end
      @(posedge clk);
      #1;
      rsp_ready[r] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready[r] = 1'b0;
      chk("idle_after_rsp", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int order[5];
      int exp_order[5] = '{0, 1, 2, 3, 0};
      int n;

      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // single request, 3-cycle latency
      set_op(0, 16'h000A, 16'h0005);
      wait_accept(0);
      wait_rsp(0, 3, 16'h000F, 1'b0, 1'b0, 0);

      // carry cases
      set_op(2, 16'hFFFF, 16'h0001);
      wait_accept(2);
      wait_rsp(2, 3, 16'h0000, 1'b1, 1'b0, 0);
      set_op(2, 16'h8000, 16'h8000);
      wait_accept(2);
      wait_rsp(2, 3, 16'h0000, 1'b1, 1'b0, 0);

      // back-pressure; other rsp_ready bits and a new request ignored
      set_op(0, 16'h1234, 16'h4321);
      wait_accept(0);
      rsp_ready = 4'b1110;
      set_op(1, 16'h7FFF, 16'h0001);
      wait_rsp(0, 3, 16'h5555, 1'b0, 1'b0, 5);
      rsp_ready = '0;
      wait_accept(1);
      wait_rsp(1, 3, 16'h8000, 1'b0, 1'b0, 0);

      // FU never acks
      fu_stall = 1'b1;
      set_op(3, 16'h1234, 16'h1111);
      wait_accept(3);
`ifdef ADDER_FU_ARB_TIMEOUT_EN
      wait_rsp(3, 9, 16'h0000, 1'b0, 1'b1, 0);
      fu_stall = 1'b0;
`else
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("stall_on_off", fu_on_off, 1);
         chk("stall_no_rsp", rsp_valid, 0);
      end
      @(posedge clk);
      #1;
      fu_stall = 1'b0;
      wait_rsp(3, 0, 16'h2345, 1'b0, 1'b0, 0);
`endif

      // reset while in EXEC
      set_op(1, 16'h0101, 16'h0202);
      wait_accept(1);
      chk("pre_rst_busy", busy, 1);
      #2;
      reset = 1'b1;
      #1;
      chk_rst("mid_rst");
      @(posedge clk);
      #1;
      reset = 1'b0;
      set_op(0, 16'h0003, 16'h0004);
      set_op(2, 16'h0030, 16'h0040);
      @(negedge clk);
      chk("post_rst_grant", req_ready, 4'b0001);
      @(posedge clk);
      #1;
      req_valid = '0;
      wait_rsp(0, 3, 16'h0007, 1'b0, 1'b0, 0);

      // fairness under continuous requests from everyone
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < N; i++)
         set_op(i, 16'(16'h1000 * (i + 1)), 16'(i));
      for (int t = 0; t < 5; t++) begin
         n = 0;
         @(negedge clk);
         while (req_ready == 0 && n < 40) begin
            @(negedge clk);
            n++;
         end
         order[t] = -1;
         for (int i = 0; i < N; i++)
            if (req_ready[i]) order[t] = i;
         chk("fair_order", order[t], exp_order[t]);
         @(posedge clk);
         #1;
         if (t == 4) req_valid = '0;
         n = 0;
         @(negedge clk);
         while (rsp_valid == 0 && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("fair_rsp_seen", rsp_valid != 0, 1);
         @(posedge clk);
         #1;
         rsp_ready = '1;
         @(posedge clk);
         #1;
         rsp_ready = '0;
      end
      repeat (3) @(negedge clk);
      chk("end_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
